// File: rtl/clk_div_pkg.sv
// Shared helpers for the integer clock divider: counter width, high-phase
// length and the default division ratio.
package clk_div_pkg;

  localparam int CLK_DIV_DEFAULT = 7;

  function automatic int cnt_width(input int div);
    return $clog2(div);
  endfunction

  // Rising-edge high count; odd ratios round down and rely on the
  // falling-edge stage to add the missing half period.
  function automatic int high_count(input int div);
    return (div % 2 == 1) ? (div - 1) / 2 : div / 2;
  endfunction

endpackage

// File: rtl/clk_div_negedge_stage.sv
// Single falling-edge retiming flop with asynchronous active-high reset,
// kept in its own module so negedge-path constraints live in one place.
module clk_div_negedge_stage
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic q_n_q;

  always_ff @(negedge clk or posedge rstn) begin
    if (rstn) q_n_q <= 1'b0;
    else      q_n_q <= d;
  end

  assign q = q_n_q;

endmodule

// File: rtl/clk_div_by_7.sv
// Integer clock divider, out_clk = clk / DIV. Define CLKDIV_DUTY50_EN to
// build the falling-edge stage that gives odd ratios a 50% duty cycle.
module clk_div_by_7
  import clk_div_pkg::*;
#(
  parameter int DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  output logic out_clk
);

  localparam int CW_RAW = cnt_width(DIV);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int H      = high_count(DIV);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] H_CNT   = CW'(H);

  if (DIV < 2) begin : g_bad_div
    $error("clk_div_by_7: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_p_q, cnt_p_d;
  logic          q_p_q, q_p_d;

  // q_p looks at the pre-edge count, so it rises on the first edge after reset.
  always_comb begin
    cnt_p_d = (cnt_p_q == CNT_MAX) ? '0 : cnt_p_q + 1'b1;
    q_p_d   = (cnt_p_q < H_CNT);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_p_q <= '0;
      q_p_q   <= 1'b0;
    end else begin
      cnt_p_q <= cnt_p_d;
      q_p_q   <= q_p_d;
    end
  end

`ifdef CLKDIV_DUTY50_EN
  if (DIV % 2 == 1) begin : g_duty50
    logic q_n;

    clk_div_negedge_stage u_neg (
      .clk  (clk),
      .rstn (rstn),
      .d    (q_p_q),
      .q    (q_n)
    );

    // q_n trails q_p by half a period, stretching the high phase to DIV/2.
    assign out_clk = q_p_q | q_n;
  end else begin : g_direct
    assign out_clk = q_p_q;
  end
`else
  assign out_clk = q_p_q;
`endif

endmodule

// File: tb/tb_clk_div_by_7.sv
// Scoreboard bench for clk_div_by_7: expected out_clk edges (time, level)
// are queued by the stimulus and consumed by per-DUT edge monitors.
module tb_clk_div_by_7;

`ifdef CLKDIV_DUTY50_EN
  localparam bit D50 = 1'b1;
`else
  localparam bit D50 = 1'b0;
`endif

  localparam longint LONG_E1 = 175;
  localparam longint STOP    = 70172;

  typedef struct {
    longint t;
    bit     v;
  } ev_t;

  logic clk = 1'b0;
  logic rstn;
  logic o7, o4;

  ev_t q7[$];
  ev_t q4[$];
  int  total  = 0;
  int  bad    = 0;
  int  rises7 = 0;

  clk_div_by_7 u_dut7 (
    .clk     (clk),
    .rstn    (rstn),
    .out_clk (o7)
  );

  clk_div_by_7 #(.DIV(4)) u_dut4 (
    .clk     (clk),
    .rstn    (rstn),
    .out_clk (o4)
  );

  always #5 clk = ~clk;

  task automatic chk_edge(input string name, input longint act_t, input bit act_v, input ev_t exp);
    total++;
    if (act_t != exp.t || act_v != exp.v) begin
      bad++;
      $display("FAIL %s: got edge to %0b at t=%0d, want edge to %0b at t=%0d",
               name, act_v, act_t, exp.v, exp.t);
    end
  endtask

  task automatic chk_lvl(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0d", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input longint t, input bit v);
    ev_t e;
    e.t = t;
    e.v = v;
    if (sel == 7) q7.push_back(e);
    else          q4.push_back(e);
  endtask

  // Reference waveform: rise every div clocks starting at e1; high for
  // div/2 clocks, or div/2 exact periods (half-clock resolution) in 50% odd mode.
  task automatic push_wave(input int div, input longint e1, input longint stop);
    longint hi;
    hi = (div % 2 == 1 && D50) ? longint'(div * 5) : longint'((div / 2) * 10);
    for (longint r = e1; r < stop; r += longint'(div * 10)) begin
      push(div, r, 1'b1);
      if (r + hi < stop) push(div, r + hi, 1'b0);
    end
  endtask

  always @(o7) begin
    if ($time != 0) begin
      if (o7 && longint'($time) >= LONG_E1) rises7++;
      if (q7.size() == 0) begin
        total++;
        bad++;
        $display("FAIL div7_extra_edge: got edge to %0b at t=%0d, want no edge", o7, $time);
      end else begin
        chk_edge("div7_edge", longint'($time), o7, q7.pop_front());
      end
    end
  end

  always @(o4) begin
    if ($time != 0) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL div4_extra_edge: got edge to %0b at t=%0d, want no edge", o4, $time);
      end else begin
        chk_edge("div4_edge", longint'($time), o4, q4.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b1;
    #1;
    chk_lvl("reset_div7_t1", o7, 1'b0);
    chk_lvl("reset_div4_t1", o4, 1'b0);
    #54;
    chk_lvl("reset_div7_hold", o7, 1'b0);
    chk_lvl("reset_div4_hold", o4, 1'b0);

    // Release at 62; E1 is the rising edge at 65.
    push(7, 65, 1'b1);
    push(7, D50 ? 100 : 95, 1'b0);
    push(7, 135, 1'b1);
    push(4, 65, 1'b1);
    push(4, 85, 1'b0);
    push(4, 105, 1'b1);
    push(4, 125, 1'b0);
    push(4, 145, 1'b1);
    #7 rstn = 1'b0;

    // Reset 15 after the 135 rise: both outputs must drop in that timestep.
    #88;
    push(7, 150, 1'b0);
    push(4, 150, 1'b0);
    rstn = 1'b1;
    #1;
    chk_lvl("midreset_div7", o7, 1'b0);
    chk_lvl("midreset_div4", o4, 1'b0);

    // Release at 172; restart with E1 at 175 and run 1000 div-7 periods.
    #21;
    push_wave(7, LONG_E1, STOP);
    push_wave(4, LONG_E1, STOP);
    rstn = 1'b0;
    #(STOP - 172);

    total++;
    if (rises7 != 1000) begin
      bad++;
      $display("FAIL div7_rise_count: got %0d want 1000", rises7);
    end
    while (q7.size() != 0) begin
      ev_t e;
      e = q7.pop_front();
      total++;
      bad++;
      $display("FAIL div7_missing_edge: got none, want edge to %0b at t=%0d", e.v, e.t);
    end
    while (q4.size() != 0) begin
      ev_t e;
      e = q4.pop_front();
      total++;
      bad++;
      $display("FAIL div4_missing_edge: got none, want edge to %0b at t=%0d", e.v, e.t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
